// File: rtl/segs_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph table,
// segment bit order and pin polarity helper.
package segs_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Segment vector in gfedcba order, 1 = lit, before polarity.
  typedef logic [SEG_G:SEG_A] seg_t;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Idle level of a display pin; doubles as the XOR mask applied to lit levels.
  function automatic logic inactive_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to gfedcba glyph decoder with a blanking override.
module seg_hex_decoder
  import segs_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg
);

  // NOTE: default first so every path assigns o_seg and no latch is inferred.
  always_comb begin
    o_seg = GLYPH_TABLE[i_nibble];
    if (i_blank) o_seg = '0;
  end

endmodule

// File: rtl/segs_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with double-buffered
// load, blink, leading-zero blanking and selectable pin polarity.
module segs_scan_ctrl
  import segs_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_enables,
  input  logic [DIGITS-1:0]     load_points,
  input  logic [DIGITS-1:0]     load_blink,
  input  logic                  lz_blank,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);
  localparam logic [FR_W-1:0]  LAST_FR  = FR_W'(BLINK_FRAMES - 1);
  localparam logic             POL      = inactive_level(ACTIVE_LOW);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] data;
    logic [DIGITS-1:0]      en;
    logic [DIGITS-1:0]      pt;
    logic [DIGITS-1:0]      bl;
  } disp_t;

  disp_t             r_active;
  disp_t             r_shadow;
  logic              r_pending;
  logic              r_phase;
  logic              r_frame_tick;
  logic [PS_W-1:0]   r_presc;
  logic [IDX_W-1:0]  r_idx;
  logic [FR_W-1:0]   r_frame;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [DIGITS-1:0] r_an;

  logic              w_slot_tick;
  logic              w_frame_end;
  logic              w_capture;
  logic              w_dark;
  logic              w_lz_blank;
  logic [DIGITS-1:0] w_upper_zero;
  logic [DIGITS-1:0] w_an_hot;
  seg_t              w_glyph;

  assign w_slot_tick = (r_presc == LAST_PS);
  assign w_frame_end = w_slot_tick && (r_idx == LAST_IDX);
  assign w_capture   = load && !r_pending;

  // w_upper_zero[i]: digit i and every digit above it hold nibble 0.
  always_comb begin
    logic v_zero;
    v_zero       = 1'b1;
    w_upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_zero          = v_zero && (r_active.data[i] == 4'h0);
      w_upper_zero[i] = v_zero;
    end
  end

  always_comb begin
    w_an_hot = '0;
    for (int i = 0; i < DIGITS; i++) w_an_hot[i] = (r_idx == IDX_W'(i));
  end

  assign w_dark     = r_active.bl[r_idx] && r_phase;
  assign w_lz_blank = lz_blank && (r_idx != '0) && w_upper_zero[r_idx];

  seg_hex_decoder u_decoder (
    .i_nibble (r_active.data[r_idx]),
    .i_blank  (w_dark || w_lz_blank),
    .o_seg    (w_glyph)
  );

  // NOTE: display buffers are reset too: an idle display must be dark, and a
  // reset has to discard a pending load rather than let it commit later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_phase      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_seg        <= {7{POL}};
      r_dp         <= POL;
      r_an         <= {DIGITS{POL}};
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge state.
      r_presc      <= w_slot_tick ? '0 : r_presc + PS_W'(1);
      r_frame_tick <= w_frame_end;
      if (w_slot_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);

      if (w_frame_end) begin
        if (r_frame == LAST_FR) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FR_W'(1);
        end
        if (r_pending) begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
        end
      end

      // Capture requires an empty shadow, so it never overlaps a commit.
      if (w_capture) begin
        r_shadow  <= '{data: load_data, en: load_enables, pt: load_points, bl: load_blink};
        r_pending <= 1'b1;
      end

      if (r_active.en[r_idx]) begin
        r_an  <= w_an_hot ^ {DIGITS{POL}};
        r_seg <= w_glyph ^ {7{POL}};
        r_dp  <= (r_active.pt[r_idx] && !w_dark) ^ POL;
      end else begin
        r_an  <= {DIGITS{POL}};
        r_seg <= {7{POL}};
        r_dp  <= POL;
      end
    end
  end

  assign ready      = ~r_pending;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_segs_scan_ctrl.sv
// Self-checking bench: two controller instances (active-high and active-low)
// driven by shared stimulus and compared every cycle to a behavioural model.
module tb_segs_scan_ctrl;

  localparam int D = 6;
  localparam int P_M  [2] = '{4, 1};
  localparam int BF_M [2] = '{2, 1};
  localparam bit AL_M [2] = '{1'b0, 1'b1};
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [4*D-1:0] data;
    logic [D-1:0]   en;
    logic [D-1:0]   pt;
    logic [D-1:0]   bl;
  } set_t;

  logic           clk;
  logic           rst;
  logic           load;
  logic [4*D-1:0] load_data;
  logic [D-1:0]   load_enables;
  logic [D-1:0]   load_points;
  logic [D-1:0]   load_blink;
  logic           lz_blank;

  logic           ready_a, dp_a, ft_a, ready_b, dp_b, ft_b;
  logic [6:0]     seg_a, seg_b;
  logic [D-1:0]   an_a, an_b;

  int n_pass  = 0;
  int n_total = 0;

  segs_scan_ctrl #(.DIGITS(D), .PRESCALE(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .load_enables(load_enables), .load_points(load_points), .load_blink(load_blink),
    .lz_blank(lz_blank), .ready(ready_a), .seg(seg_a), .dp(dp_a), .an(an_a),
    .frame_tick(ft_a)
  );

  segs_scan_ctrl #(.DIGITS(D), .PRESCALE(1), .BLINK_FRAMES(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .load_enables(load_enables), .load_points(load_points), .load_blink(load_blink),
    .lz_blank(lz_blank), .ready(ready_b), .seg(seg_b), .dp(dp_b), .an(an_b),
    .frame_tick(ft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
  endtask

  // ---------------- behavioural model ----------------
  // State is an edge count since reset release; index, frame and blink phase
  // follow from it by division. Only the load buffers are tracked explicitly.
  int         e_m    [2];
  bit         pend_m [2];
  set_t       act_m  [2];
  set_t       shd_m  [2];
  logic [6:0] exp_seg [2];
  logic       exp_dp  [2];
  logic [D-1:0] exp_an [2];
  logic       exp_ft  [2];

  task automatic model_reset(input int k);
    e_m[k]     = 0;
    pend_m[k]  = 1'b0;
    act_m[k]   = '0;
    shd_m[k]   = '0;
    exp_seg[k] = AL_M[k] ? 7'h7F : 7'h00;
    exp_dp[k]  = AL_M[k];
    exp_an[k]  = AL_M[k] ? 6'h3F : 6'h00;
    exp_ft[k]  = 1'b0;
  endtask

  task automatic model_step(input int k);
    int idx, frame, phase, frame_len;
    set_t s;
    logic dark, lzb;
    logic [6:0] sv;
    logic dv;
    logic [D-1:0] av;
    frame_len = P_M[k] * D;
    idx   = (e_m[k] / P_M[k]) % D;
    frame = e_m[k] / frame_len;
    phase = (frame / BF_M[k]) % 2;
    s     = act_m[k];
    sv = 7'h00; dv = 1'b0; av = '0;
    if (s.en[idx]) begin
      dark = s.bl[idx] && (phase == 1);
      lzb  = lz_blank && (idx != 0) && ((s.data >> (4 * idx)) == 0);
      av   = D'(1 << idx);
      sv   = (dark || lzb) ? 7'h00 : GLYPH[s.data[4*idx +: 4]];
      dv   = s.pt[idx] && !dark;
    end
    exp_seg[k] = AL_M[k] ? ~sv : sv;
    exp_dp[k]  = AL_M[k] ? ~dv : dv;
    exp_an[k]  = AL_M[k] ? ~av : av;
    exp_ft[k]  = ((e_m[k] + 1) % frame_len) == 0;
    if (exp_ft[k] && pend_m[k]) begin
      act_m[k]  = shd_m[k];
      pend_m[k] = 1'b0;
    end else if (load && !pend_m[k]) begin
      shd_m[k]  = '{data: load_data, en: load_enables, pt: load_points, bl: load_blink};
      pend_m[k] = 1'b1;
    end
    e_m[k]++;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else     model_step(k);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("seg_a",   {25'd0, seg_a},  {25'd0, exp_seg[0]});
    check("dp_a",    {31'd0, dp_a},   {31'd0, exp_dp[0]});
    check("an_a",    {26'd0, an_a},   {26'd0, exp_an[0]});
    check("ready_a", {31'd0, ready_a}, {31'd0, !pend_m[0]});
    check("ft_a",    {31'd0, ft_a},   {31'd0, exp_ft[0]});
    check("seg_b",   {25'd0, seg_b},  {25'd0, exp_seg[1]});
    check("dp_b",    {31'd0, dp_b},   {31'd0, exp_dp[1]});
    check("an_b",    {26'd0, an_b},   {26'd0, exp_an[1]});
    check("ready_b", {31'd0, ready_b}, {31'd0, !pend_m[1]});
    check("ft_b",    {31'd0, ft_b},   {31'd0, exp_ft[1]});
  end

  // ---------------- directed helpers ----------------
  task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] en,
                         input logic [D-1:0] pt, input logic [D-1:0] bl);
    load_data = d; load_enables = en; load_points = pt; load_blink = bl;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // what: 0 = ready_a high, 1 = an_a equals an_val, 2 = frame_tick_a high.
  task automatic wait_for(input int what, input logic [D-1:0] an_val, input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      case (what)
        0:       found = ready_a;
        1:       found = (an_a == an_val);
        default: found = ft_a;
      endcase
    end
    check(nm, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int cnt;
    bit lit [6];
    logic [4*D-1:0] rd;

    rst = 1'b1; load = 1'b0; lz_blank = 1'b0;
    load_data = '0; load_enables = '0; load_points = '0; load_blink = '0;

    // Reset values, both polarities
    repeat (3) @(negedge clk);
    check("rst_seg_a", {25'd0, seg_a}, 32'h00);
    check("rst_dp_a", {31'd0, dp_a}, 32'd0);
    check("rst_an_a", {26'd0, an_a}, 32'h00);
    check("rst_ready_a", {31'd0, ready_a}, 32'd1);
    check("rst_ft_a", {31'd0, ft_a}, 32'd0);
    check("rst_seg_b", {25'd0, seg_b}, 32'h7F);
    check("rst_an_b", {26'd0, an_b}, 32'h3F);
    #2 rst = 1'b0;

    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (an_a != 0) cnt++;
    end
    check("idle_dark_cycles", cnt, 0);

    // Basic scan: 0x123456, all enabled
    do_load(24'h123456, 6'h3F, 6'h00, 6'h00);
    wait_for(0, '0, "commit_1");
    wait_for(1, 6'h01, "see_digit0");
    check("digit0_seg", {25'd0, seg_a}, 32'h7D);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an_a == 6'h01) cnt++;
      else break;
    end
    check("digit0_hold", cnt, 4);
    wait_for(1, 6'h20, "see_digit5");
    check("digit5_seg", {25'd0, seg_a}, 32'h06);
    wait_for(2, '0, "see_frame_tick");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (ft_a) break;
    end
    check("frame_period", cnt, 24);

    // Handshake: second load while busy is ignored
    do_load(24'h111111, 6'h3F, 6'h00, 6'h00);
    @(negedge clk);
    check("ready_low_busy", {31'd0, ready_a}, 32'd0);
    do_load(24'h222222, 6'h3F, 6'h00, 6'h00);
    wait_for(0, '0, "commit_2");
    check("ready_with_ft", {31'd0, ft_a}, 32'd1);
    wait_for(1, 6'h04, "see_digit2");
    check("shows_ones", {25'd0, seg_a}, 32'h06);

    // Leading-zero blanking
    lz_blank = 1'b1;
    do_load(24'h000050, 6'h3F, 6'h00, 6'h00);
    wait_for(0, '0, "commit_3");
    wait_for(1, 6'h08, "lz_see_digit3");
    check("lz_digit3_blank", {25'd0, seg_a}, 32'h00);
    wait_for(1, 6'h02, "lz_see_digit1");
    check("lz_digit1", {25'd0, seg_a}, 32'h6D);
    wait_for(1, 6'h01, "lz_see_digit0");
    check("lz_digit0", {25'd0, seg_a}, 32'h3F);
    lz_blank = 1'b0;
    wait_for(1, 6'h08, "nolz_see_digit3");
    check("nolz_digit3", {25'd0, seg_a}, 32'h3F);

    // Blink on digit 0 with its point set
    do_load(24'h123456, 6'h3F, 6'h01, 6'h01);
    wait_for(0, '0, "commit_4");
    for (int f = 0; f < 6; f++) begin
      wait_for(1, 6'h01, "blink_see_digit0");
      lit[f] = (seg_a != 7'h00);
      check("blink_dp_follows", {31'd0, dp_a}, {31'd0, lit[f]});
      wait_for(1, 6'h02, "blink_see_digit1");
      check("blink_digit1_steady", {25'd0, seg_a}, 32'h6D);
    end
    check("blink_alt_0_2", {31'd0, lit[0] != lit[2]}, 32'd1);
    check("blink_alt_1_3", {31'd0, lit[1] != lit[3]}, 32'd1);
    check("blink_pairs", {31'd0, (lit[0] == lit[1]) ^ (lit[1] == lit[2])}, 32'd1);

    // Reset with a pending load
    do_load(24'h888888, 6'h3F, 6'h3F, 6'h00);
    check("pend_ready_low", {31'd0, ready_a}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_seg_a", {25'd0, seg_a}, 32'h00);
    check("mid_rst_dp_a", {31'd0, dp_a}, 32'd0);
    check("mid_rst_an_a", {26'd0, an_a}, 32'h00);
    check("mid_rst_ready_a", {31'd0, ready_a}, 32'd1);
    check("mid_rst_seg_b", {25'd0, seg_b}, 32'h7F);
    check("mid_rst_dp_b", {31'd0, dp_b}, 32'd1);
    check("mid_rst_an_b", {26'd0, an_b}, 32'h3F);
    @(negedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (an_a != 0) cnt++;
    end
    check("pending_discarded", cnt, 0);

    // Random traffic against the model
    repeat (3000) begin
      @(negedge clk);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        for (int j = 0; j < D; j++)
          rd[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        load_data    = rd;
        load_enables = 6'($urandom_range(0, 63));
        load_points  = 6'($urandom_range(0, 63));
        load_blink   = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    load = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
